// File: rtl/dual_port_sram.sv
// dual_port_sram: true dual-port synchronous SRAM, write-first with port A winning same-address write collisions
module dual_port_sram #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10,
  localparam int MEM_DEPTH = 1 << ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we_a,
  input  logic [ADDR_WIDTH-1:0] addr_a,
  input  logic [DATA_WIDTH-1:0] din_a,
  output logic [DATA_WIDTH-1:0] dout_a,
  input  logic                  we_b,
  input  logic [ADDR_WIDTH-1:0] addr_b,
  input  logic [DATA_WIDTH-1:0] din_b,
  output logic [DATA_WIDTH-1:0] dout_b
);
  logic [DATA_WIDTH-1:0] r_mem [MEM_DEPTH];
  logic [DATA_WIDTH-1:0] r_dout_a, r_dout_b;
  logic [DATA_WIDTH-1:0] w_next_a, w_next_b;
  logic                  w_same;
  assign w_same = addr_a == addr_b;
  // Port A's write data takes precedence whenever it targets the address port B sees.
  always_comb begin
    w_next_a = we_a ? din_a : (we_b && w_same) ? din_b : r_mem[addr_a];
    w_next_b = (we_a && w_same) ? din_a : we_b ? din_b : r_mem[addr_b];
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (we_a) r_mem[addr_a] <= din_a;
      if (we_b && !(we_a && w_same)) r_mem[addr_b] <= din_b;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_dout_a <= '0;
      r_dout_b <= '0;
    end else begin
      r_dout_a <= w_next_a;
      r_dout_b <= w_next_b;
    end
  end
  assign dout_a = r_dout_a;
  assign dout_b = r_dout_b;
endmodule

// File: tb/tb_dual_port_sram.sv
// tb_dual_port_sram: directed vectors with a queued scoreboard checked one cycle after each drive
module tb_dual_port_sram;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        we_a = 1'b0, we_b = 1'b0;
  logic [9:0]  addr_a = '0, addr_b = '0;
  logic [31:0] din_a = '0, din_b = '0;
  logic [31:0] dout_a, dout_b;
  int passed = 0;
  int total = 0;
  typedef struct {
    logic        ca;
    logic        cb;
    logic [31:0] ea;
    logic [31:0] eb;
    int          id;
  } exp_t;
  exp_t q[$];
  int n_id = 0;
  dual_port_sram dut (
    .clk(clk), .rst(rst),
    .we_a(we_a), .addr_a(addr_a), .din_a(din_a), .dout_a(dout_a),
    .we_b(we_b), .addr_b(addr_b), .din_b(din_b), .dout_b(dout_b)
  );
  always #5 clk = ~clk;
  // Each entry pushed at a negedge describes the outputs after the following posedge.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (q.size() > 0) begin
      e = q.pop_front();
      if (e.ca) begin
        total++;
        if (dout_a === e.ea) passed++;
        else $display("FAIL vec%0d dout_a got %h expected %h", e.id, dout_a, e.ea);
      end
      if (e.cb) begin
        total++;
        if (dout_b === e.eb) passed++;
        else $display("FAIL vec%0d dout_b got %h expected %h", e.id, dout_b, e.eb);
      end
    end
  end
  task automatic cyc(input logic r,
                     input logic wa, input logic [9:0] aa, input logic [31:0] da,
                     input logic wb, input logic [9:0] ab, input logic [31:0] db,
                     input logic ca, input logic [31:0] ea,
                     input logic cb, input logic [31:0] eb);
    exp_t e;
    @(negedge clk);
    rst = r; we_a = wa; addr_a = aa; din_a = da; we_b = wb; addr_b = ab; din_b = db;
    e.ca = ca; e.cb = cb; e.ea = ea; e.eb = eb; e.id = n_id++;
    q.push_back(e);
  endtask
  initial begin
    //  rst wa  aa    da            wb  ab    db            ca  ea            cb  eb
    cyc(1, 0, 10'd0,   32'h0,        0, 10'd0,   32'h0,        1, 32'h0,        1, 32'h0);
    cyc(0, 1, 10'd10,  32'hA5A5A5A5, 0, 10'd11,  32'h0,        1, 32'hA5A5A5A5, 0, 32'h0);
    cyc(0, 0, 10'd10,  32'h0,        0, 10'd10,  32'h0,        1, 32'hA5A5A5A5, 1, 32'hA5A5A5A5);
    cyc(0, 0, 10'd11,  32'h0,        1, 10'd10,  32'h5A5A5A5A, 0, 32'h0,        1, 32'h5A5A5A5A);
    cyc(0, 0, 10'd10,  32'h0,        0, 10'd10,  32'h0,        1, 32'h5A5A5A5A, 1, 32'h5A5A5A5A);
    cyc(0, 1, 10'd20,  32'hDEADBEEF, 1, 10'd20,  32'hFEEDFACE, 1, 32'hDEADBEEF, 1, 32'hDEADBEEF);
    cyc(0, 0, 10'd20,  32'h0,        0, 10'd20,  32'h0,        1, 32'hDEADBEEF, 1, 32'hDEADBEEF);
    cyc(0, 1, 10'd30,  32'h11111111, 0, 10'd30,  32'h0,        1, 32'h11111111, 1, 32'h11111111);
    cyc(0, 0, 10'd30,  32'h0,        1, 10'd30,  32'h22222222, 1, 32'h22222222, 1, 32'h22222222);
    cyc(0, 0, 10'd30,  32'h0,        0, 10'd10,  32'h0,        1, 32'h22222222, 1, 32'h5A5A5A5A);
    cyc(0, 1, 10'd0,   32'h1,        1, 10'd1023, 32'hFFFFFFFF, 1, 32'h1,       1, 32'hFFFFFFFF);
    cyc(0, 0, 10'd1023, 32'h0,       0, 10'd0,   32'h0,        1, 32'hFFFFFFFF, 1, 32'h1);
    cyc(0, 1, 10'd5,   32'hCAFEF00D, 0, 10'd20,  32'h0,        1, 32'hCAFEF00D, 1, 32'hDEADBEEF);
    cyc(1, 1, 10'd5,   32'h0,        1, 10'd5,   32'h12345678, 1, 32'h0,        1, 32'h0);
    cyc(0, 0, 10'd5,   32'h0,        0, 10'd5,   32'h0,        1, 32'hCAFEF00D, 1, 32'hCAFEF00D);
    cyc(0, 0, 10'd20,  32'h0,        0, 10'd0,   32'h0,        1, 32'hDEADBEEF, 1, 32'h1);
    for (int i = 0; i < 5 && q.size() > 0; i++) @(negedge clk);
    if (q.size() > 0) begin
      total++;
      $display("FAIL drain %0d entries left expected 0", q.size());
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
